// File: rtl/elev_pkg.sv
// Shared definitions for the five-floor elevator car model and controller.
//   car_state_e   : car/door FSM states
//   car_cmd_e     : result of decoding the motor command inputs
//   floor_onehot  : floor number (1..NUM_FLOORS) to one-hot sensor vector
//   decode_cmd    : motor command priority decode against the current floor
package elev_pkg;

    localparam int NUM_FLOORS = 5;

    typedef enum logic [2:0] {
        AT_FLOOR,
        DOOR_OPENING,
        DOOR_HELD,
        DOOR_CLOSING,
        TRAVEL
    } car_state_e;

    typedef enum logic [1:0] {
        CMD_HOLD,
        CMD_ERR,
        CMD_UP,
        CMD_DOWN
    } car_cmd_e;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [2:0] pos);
        logic [NUM_FLOORS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (int'(pos) == i + 1) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    function automatic car_cmd_e decode_cmd(input logic up, input logic down,
                                            input logic stop, input logic [2:0] pos);
        if (stop || (!up && !down)) return CMD_HOLD;
        if (up && down) return CMD_ERR;
        if ((up && pos == 3'(NUM_FLOORS)) || (down && pos == 3'd1)) return CMD_ERR;
        return up ? CMD_UP : CMD_DOWN;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Shared travel/door down-counter for the elevator car model.
//   clk, RESET_n  : clock, async active-low reset (count clears to 0)
//   load_i        : load load_val_i (wins over decrement)
//   load_val_i    : reload value
//   dec_i         : decrement, saturating at 0
//   zero_o        : current count is 0
//   zero_next_o   : count after this edge will be 0
module elev_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         RESET_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         zero_next_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign zero_o      = (cnt_q == '0);
    assign zero_next_o = (cnt_d == '0);

endmodule

// File: rtl/elevator_car_model.sv
// Car-and-shaft plant model: consumes motor/door commands, produces floor sensors.
//   clk, RESET_n          : clock, async active-low reset
//   Up, Down, Stop, Door3 : motor and door commands (Stop has highest priority)
//   Floor1..Floor5        : one-hot floor alignment sensors
//   moving                : car between floors
//   door_open/door_closed : door fully open / fully closed
//   cmd_err               : one-cycle pulse per ignored illegal command
//
// state        | meaning
// AT_FLOOR     | parked, door closed
// DOOR_OPENING | door opening, timer running
// DOOR_HELD    | door fully open
// DOOR_CLOSING | door closing, timer running
// TRAVEL       | moving between floors; tmr==0 is the arrival cycle
module elevator_car_model
    import elev_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int START_FLOOR   = 1
) (
    input  logic clk,
    input  logic RESET_n,
    input  logic Up,
    input  logic Down,
    input  logic Stop,
    input  logic Door3,
    output logic Floor1,
    output logic Floor2,
    output logic Floor3,
    output logic Floor4,
    output logic Floor5,
    output logic moving,
    output logic door_open,
    output logic door_closed,
    output logic cmd_err
);

    localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);

    // A span from rest loads the full count; the arrival cycle (tmr==0, new
    // sensor visible) is part of every span, so a continuing span reloads one
    // less to keep the floor-to-floor spacing at TRAVEL_CYCLES edges.
    localparam logic [TW-1:0] TRAVEL_FULL   = TW'(TRAVEL_CYCLES);
    localparam logic [TW-1:0] TRAVEL_RELOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_RELOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [2:0]    START_POS     = 3'(START_FLOOR);

    car_state_e state_q, state_d;
    logic [2:0] pos_q, pos_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;

    logic          tmr_load, tmr_dec, tmr_zero, tmr_zero_next;
    logic [TW-1:0] tmr_val;
    car_cmd_e      cmd;

    elev_timer #(.W(TW)) u_timer (
        .clk         (clk),
        .RESET_n     (RESET_n),
        .load_i      (tmr_load),
        .load_val_i  (tmr_val),
        .dec_i       (tmr_dec),
        .zero_o      (tmr_zero),
        .zero_next_o (tmr_zero_next)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        cmd      = decode_cmd(Up, Down, Stop, pos_q);

        unique case (state_q)
            AT_FLOOR: begin
                if (Door3) begin
                    state_d  = DOOR_OPENING;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_RELOAD;
                    err_d    = Up | Down;
                end else begin
                    unique case (cmd)
                        CMD_ERR:  err_d = 1'b1;
                        CMD_UP, CMD_DOWN: begin
                            state_d  = TRAVEL;
                            dir_d    = (cmd == CMD_UP);
                            tmr_load = 1'b1;
                            tmr_val  = TRAVEL_FULL;
                        end
                        default: ;
                    endcase
                end
            end
            DOOR_OPENING: begin
                err_d = Up | Down;
                if (!Door3) begin
                    state_d  = DOOR_CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_RELOAD;
                end else if (tmr_zero) begin
                    state_d = DOOR_HELD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DOOR_HELD: begin
                err_d = Up | Down;
                if (!Door3) begin
                    state_d  = DOOR_CLOSING;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_RELOAD;
                end
            end
            DOOR_CLOSING: begin
                err_d = Up | Down;
                if (Door3) begin
                    state_d  = DOOR_OPENING;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_RELOAD;
                end else if (tmr_zero) begin
                    state_d = AT_FLOOR;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            TRAVEL: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    unique case (cmd)
                        CMD_HOLD: state_d = AT_FLOOR;
                        CMD_ERR: begin
                            state_d = AT_FLOOR;
                            err_d   = 1'b1;
                        end
                        default: begin
                            dir_d    = (cmd == CMD_UP);
                            tmr_load = 1'b1;
                            tmr_val  = TRAVEL_RELOAD;
                        end
                    endcase
                end
            end
            default: state_d = AT_FLOOR;
        endcase

        // The car becomes aligned with the next floor as the span timer
        // reaches zero, so the new sensor is visible in the arrival cycle.
        if ((state_d == TRAVEL) && tmr_zero_next) begin
            pos_d = dir_d ? (pos_q + 3'd1) : (pos_q - 3'd1);
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= AT_FLOOR;
            pos_q   <= START_POS;
            dir_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    logic                  aligned;
    logic [NUM_FLOORS-1:0] floor_vec;

    assign aligned     = (state_q != TRAVEL) || tmr_zero;
    assign floor_vec   = aligned ? floor_onehot(pos_q) : '0;
    assign {Floor5, Floor4, Floor3, Floor2, Floor1} = floor_vec;
    assign moving      = (state_q == TRAVEL) && !tmr_zero;
    assign door_open   = (state_q == DOOR_HELD);
    assign door_closed = (state_q == AT_FLOOR) || (state_q == TRAVEL);
    assign cmd_err     = err_q;

endmodule

// File: tb/tb_elevator_car_model.sv
// Scoreboard bench for elevator_car_model with TRAVEL_CYCLES=4, DOOR_CYCLES=3,
// START_FLOOR=1. Each driven cycle pushes the expected post-edge output vector
// {Floor5..Floor1, moving, door_open, door_closed, cmd_err}; it is popped and
// compared one time unit after the edge.
module tb_elevator_car_model;

    logic clk = 1'b0;
    logic RESET_n, Up, Down, Stop, Door3;
    logic Floor1, Floor2, Floor3, Floor4, Floor5;
    logic moving, door_open, door_closed, cmd_err;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    elevator_car_model #(
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3),
        .START_FLOOR   (1)
    ) dut (
        .clk         (clk),
        .RESET_n     (RESET_n),
        .Up          (Up),
        .Down        (Down),
        .Stop        (Stop),
        .Door3       (Door3),
        .Floor1      (Floor1),
        .Floor2      (Floor2),
        .Floor3      (Floor3),
        .Floor4      (Floor4),
        .Floor5      (Floor5),
        .moving      (moving),
        .door_open   (door_open),
        .door_closed (door_closed),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ex(input int fl, input logic mv, input logic dop,
                                      input logic dcl, input logic er);
        logic [4:0] f;
        f = '0;
        if (fl >= 1 && fl <= 5) f[fl-1] = 1'b1;
        return {f, mv, dop, dcl, er};
    endfunction

    function automatic logic [8:0] obs();
        return {Floor5, Floor4, Floor3, Floor2, Floor1, moving, door_open, door_closed, cmd_err};
    endfunction

    task automatic chk_val(input string tag, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (F5..F1 mv open closed err)", tag, got, want);
        end
    endtask

    task automatic check_now(input string tag, input logic [8:0] e);
        exp_q.push_back(e);
        chk_val(tag, obs(), exp_q.pop_front());
    endtask

    task automatic step(input logic u, input logic d, input logic s, input logic dr,
                        input logic [8:0] e, input string tag);
        Up    = u;
        Down  = d;
        Stop  = s;
        Door3 = dr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk_val(tag, obs(), exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] mv;
        mv      = ex(0, 1'b1, 1'b0, 1'b1, 1'b0);
        RESET_n = 1'b0;
        Up = 1'b0; Down = 1'b0; Stop = 1'b0; Door3 = 1'b0;

        #12;
        check_now("reset", ex(1, 1'b0, 1'b0, 1'b1, 1'b0));
        #1 RESET_n = 1'b1;

        step(0, 0, 0, 0, ex(1, 0, 0, 1, 0), "idle_f1");
        step(0, 1, 0, 0, ex(1, 0, 0, 1, 1), "down_at_f1");
        step(0, 0, 0, 0, ex(1, 0, 0, 1, 0), "err_clear");

        // one floor up, Stop in the arrival cycle
        step(1, 0, 0, 0, mv, "up_start");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, mv, "span_1_2");
        step(0, 0, 0, 0, ex(2, 0, 0, 1, 0), "arrive_f2");
        step(0, 0, 1, 0, ex(2, 0, 0, 1, 0), "stop_f2");
        step(0, 0, 0, 0, ex(2, 0, 0, 1, 0), "park_f2");

        step(1, 1, 0, 0, ex(2, 0, 0, 1, 1), "updown_f2");
        step(0, 0, 0, 0, ex(2, 0, 0, 1, 0), "updown_clear");

        // continuous Up to the top floor
        step(1, 0, 0, 0, mv, "cont_up_start");
        for (int f = 3; f <= 5; f++) begin
            for (int i = 0; i < 3; i++) step(1, 0, 0, 0, mv, "cont_up_span");
            step(1, 0, 0, 0, ex(f, 0, 0, 1, 0), "cont_up_arrive");
        end
        step(1, 0, 0, 0, ex(5, 0, 0, 1, 1), "top_err");
        step(1, 0, 0, 0, ex(5, 0, 0, 1, 1), "top_err_again");
        step(0, 0, 0, 0, ex(5, 0, 0, 1, 0), "park_f5");

        // continuous Down to floor 3, Stop on arrival
        step(0, 1, 0, 0, mv, "cont_dn_start");
        for (int f = 4; f >= 3; f--) begin
            for (int i = 0; i < 3; i++) step(0, 1, 0, 0, mv, "cont_dn_span");
            step(0, 1, 0, 0, ex(f, 0, 0, 1, 0), "cont_dn_arrive");
        end
        step(0, 0, 1, 0, ex(3, 0, 0, 1, 0), "stop_f3");

        // door cycle at floor 3, Up attempts while the door is not closed
        for (int i = 1; i <= 10; i++) begin
            logic u;
            u = (i == 2) || (i == 6);
            step(u, 0, 0, 1, ex(3, 0, (i >= 4), 0, u), "door_open_phase");
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, ex(3, 0, 0, 0, 0), "door_closing");
        step(0, 0, 0, 0, ex(3, 0, 0, 1, 0), "door_closed");

        // down one floor, then reset in the middle of the 2->3 span
        step(0, 1, 0, 0, mv, "dn_start");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, mv, "span_3_2");
        step(0, 0, 0, 0, ex(2, 0, 0, 1, 0), "arrive_f2_dn");
        step(0, 0, 1, 0, ex(2, 0, 0, 1, 0), "stop_f2_dn");
        step(1, 0, 0, 0, mv, "up_2_3_start");
        step(0, 0, 0, 0, mv, "up_2_3_mid");
        #3 RESET_n = 1'b0;
        #1 check_now("reset_mid_travel", ex(1, 0, 0, 1, 0));
        #3 RESET_n = 1'b1;
        step(0, 0, 0, 0, ex(1, 0, 0, 1, 0), "after_reset");
        step(1, 0, 0, 0, mv, "restart_up");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
